// File: rtl/decoder_seq_ctrl_if.sv
// Output stream bundle of decoder_seq_ctrl: one h_t vector per transfer.
//   out_valid  master -> slave  h_t available on out_data
//   out_ready  slave  -> master downstream accepts h_t
//   out_data   master -> slave  HIDDEN_SIZE words of DATA_WIDTH bits
//   out_last   master -> slave  qualifies the final h_t of a sequence
interface decoder_seq_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int HIDDEN_SIZE = 10
);
  logic                                   out_valid;
  logic                                   out_ready;
  logic                                   out_last;
  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/decoder_seq_ctrl.sv
// decoder_seq_ctrl: runs decoder_LSTM_cell for seq_len steps on one latent
// vector z, owns the h/c state registers that feed back as h_prev/c_prev,
// and streams every h_t out over out_if (valid/ready).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, seq_len, z_in   request; seq_len and z captured when start is taken
//   busy, done, err        status; done is a one-cycle pulse, err = watchdog
//   cell_start, cell_done  cell launch pulse / cell completion pulse
//   cell_x, cell_h, cell_c registered z, h state, c state (cell inputs)
//   cell_h_out, cell_c_out cell results, captured on cell_done
//   out_if                 master side of the h_t output stream
// Build option: define DEC_SEQ_TIMEOUT_EN to enable the WAIT watchdog.
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | cell_start pulse for the current step
// WAIT   | waiting for cell_done
// EMIT   | h_t offered on out_if until accepted
// FIN    | sequence over; done is registered from this state
module decoder_seq_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRACT_WIDTH = 24,
  parameter int INPUT_SIZE  = 10,
  parameter int HIDDEN_SIZE = 10,
  parameter int MAX_SEQ     = 64,
  parameter int TIMEOUT_CYC = 1024,
  localparam int SW = $clog2(MAX_SEQ + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [SW-1:0]                          seq_len,
  input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  z_in,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic                                   cell_start,
  input  logic                                   cell_done,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  cell_x,
  output logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_h,
  output logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_c,
  input  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_h_out,
  input  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_c_out,
  decoder_seq_ctrl_if.master                     out_if
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, EMIT, FIN} state_t;

  localparam logic [SW-1:0] MAX_LEN = SW'(MAX_SEQ);

  state_t                                 state, state_nxt;
  logic [SW-1:0]                          len_q, step_q;
  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  x_q;
  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] h_q, c_q;
  logic                                   last;
  logic                                   timeout;
  logic                                   unused_cfg;

  // Fixed-point format is only carried through; nothing here depends on it.
  assign unused_cfg = (FRACT_WIDTH > 0) ^ (TIMEOUT_CYC > 0);

  assign last = (step_q == len_q - SW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (seq_len == '0) ? FIN : LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      // A completion arriving in the same cycle as the watchdog still counts.
      WAIT:    if (cell_done) state_nxt = EMIT;
               else if (timeout) state_nxt = FIN;
      EMIT:    if (out_if.out_ready) state_nxt = last ? FIN : LAUNCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      len_q  <= '0;
      step_q <= '0;
      x_q    <= '0;
      h_q    <= '0;
      c_q    <= '0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: if (start) begin
          len_q  <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
          step_q <= '0;
          x_q    <= z_in;
          h_q    <= '0;
          c_q    <= '0;
        end
        WAIT: if (cell_done) begin
          h_q <= cell_h_out;
          c_q <= cell_c_out;
        end
        EMIT: if (out_if.out_ready && !last) step_q <= step_q + SW'(1);
        default: ;
      endcase
    end
  end

`ifdef DEC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wd_cnt;
  logic          err_q;

  // wd_cnt = cycles elapsed since cell_start of the current step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == LAUNCH || state == WAIT) wd_cnt <= wd_cnt + TW'(1);
      else                                  wd_cnt <= '0;
      if (state == IDLE && start)                       err_q <= 1'b0;
      else if (state == WAIT && !cell_done && timeout)  err_q <= 1'b1;
    end
  end

  assign timeout = (wd_cnt == TW'(TIMEOUT_CYC - 1));
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy             = (state != IDLE);
  assign cell_start       = (state == LAUNCH);
  assign cell_x           = x_q;
  assign cell_h           = h_q;
  assign cell_c           = c_q;
  assign out_if.out_valid = (state == EMIT);
  assign out_if.out_last  = (state == EMIT) && last;
  assign out_if.out_data  = h_q;

endmodule

// File: tb/tb_decoder_seq_ctrl.sv
// Self-checking bench for decoder_seq_ctrl. A cycle-level reference model
// tracks when launches, transfers and done are due, what each h_t must be,
// and what the cell must see as h_prev/c_prev.
module tb_decoder_seq_ctrl;
  localparam int DW   = 32;
  localparam int IS   = 10;
  localparam int HS   = 10;
  localparam int MAXS = 64;
  localparam int TO   = 16;
  localparam int SW   = $clog2(MAXS + 1);
  localparam int CW   = DW * HS;

  typedef logic [HS-1:0][DW-1:0] hvec_t;
  typedef logic [IS-1:0][DW-1:0] xvec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] seq_len = '0;
  xvec_t         z_in = '0;
  logic          busy, done, err, cell_start;
  logic          cell_done = 1'b0;
  xvec_t         cell_x;
  hvec_t         cell_h, cell_c;
  hvec_t         cell_h_out = '0;
  hvec_t         cell_c_out = '0;
  logic          out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit err_model = 1'b0;

  decoder_seq_ctrl_if #(.DATA_WIDTH(DW), .HIDDEN_SIZE(HS)) out_if ();
  assign out_if.out_ready = out_ready;

  decoder_seq_ctrl #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(24), .INPUT_SIZE(IS), .HIDDEN_SIZE(HS),
    .MAX_SEQ(MAXS), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len), .z_in(z_in),
    .busy(busy), .done(done), .err(err), .cell_start(cell_start),
    .cell_done(cell_done), .cell_x(cell_x), .cell_h(cell_h), .cell_c(cell_c),
    .cell_h_out(cell_h_out), .cell_c_out(cell_c_out), .out_if(out_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic hvec_t rand_h();
    hvec_t v;
    for (int i = 0; i < HS; i++) v[i] = $urandom;
    return v;
  endfunction

  function automatic xvec_t rand_x();
    xvec_t v;
    for (int i = 0; i < IS; i++) v[i] = $urandom;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_err"},       err, 0);
    check({tag, "_cell_start"}, cell_start, 0);
    check({tag, "_out_valid"}, out_if.out_valid, 0);
    check({tag, "_out_last"},  out_if.out_last, 0);
    check({tag, "_out_data"},  out_if.out_data, 0);
    check({tag, "_cell_h"},    cell_h, 0);
    check({tag, "_cell_c"},    cell_c, 0);
    check({tag, "_cell_x"},    cell_x, 0);
  endtask

  // One full sequence. Cycle 0 is the cycle in which start is presented.
  // hold_len: cycles out_ready is held low at the start of every EMIT.
  // to_mode: the cell never answers (watchdog build only).
  task automatic run_seq(input int len_in, input int hold_len, input int ready_pct,
                         input bit to_mode, input bit fixed_first);
    int    eff, c, exp_launch, exp_done, launch_cyc, step, hold, wcnt;
    bit    valid_exp, pending, finished, become_valid;
    hvec_t h_prev, c_prev;
    xvec_t z;
    eff = (len_in == 0) ? 0 : ((len_in > MAXS) ? MAXS : len_in);
    z = rand_x();
    @(negedge clk);
    check("err_hold", err, err_model);
    start = 1'b1; seq_len = SW'(len_in); z_in = z;
    h_prev = '0; c_prev = '0; step = 0; hold = 0; wcnt = 0;
    pending = 1'b0; valid_exp = 1'b0; finished = 1'b0; launch_cyc = -1;
    exp_launch = (eff > 0) ? 1 : -1;
    exp_done   = (eff == 0) ? 2 : -1;
    c = 0;
    while (!finished && c < 5000) begin
      @(negedge clk);
      c++;
      start = 1'b0; cell_done = 1'b0; become_valid = 1'b0;
      check("busy", busy, (exp_done < 0) || (c < exp_done));
      check("done", done, c == exp_done);
      check("cell_start", cell_start, c == exp_launch);
      check("out_valid", out_if.out_valid, valid_exp);
      check("err", err, to_mode && launch_cyc >= 0 && c >= launch_cyc + TO);
      if (cell_start) begin
        check("cell_h_prev", cell_h, h_prev);
        check("cell_c_prev", cell_c, c_prev);
        check("cell_x", cell_x, z);
        launch_cyc = c; exp_launch = -1;
        if (to_mode) exp_done = c + TO + 1;
        else begin pending = 1'b1; wcnt = $urandom_range(1, 6); end
        if ($urandom_range(0, 1) == 1) begin
          // completion during LAUNCH must be ignored
          cell_done = 1'b1; cell_h_out = rand_h(); cell_c_out = rand_h();
        end
      end else if (pending) begin
        wcnt--;
        if (wcnt == 0) begin
          if (fixed_first && step == 0) begin
            for (int i = 0; i < HS; i++) begin
              h_prev[i] = 32'h0012_3456; c_prev[i] = 32'h0065_4321;
            end
          end else begin
            h_prev = rand_h(); c_prev = rand_h();
          end
          cell_h_out = h_prev; cell_c_out = c_prev; cell_done = 1'b1;
          pending = 1'b0; become_valid = 1'b1;
        end
      end
      if (valid_exp) begin
        check("out_data", out_if.out_data, h_prev);
        check("out_last", out_if.out_last, step == eff - 1);
        if (hold > 0) begin
          out_ready = 1'b0; hold--;
          if ($urandom_range(0, 1) == 1) begin
            cell_done = 1'b1; cell_h_out = rand_h(); cell_c_out = rand_h();
          end
        end else begin
          out_ready = ($urandom_range(1, 100) <= ready_pct);
        end
        if (out_ready) begin
          valid_exp = 1'b0;
          if (step == eff - 1) exp_done = c + 2;
          else exp_launch = c + 1;
          step++;
        end
      end else begin
        out_ready = ($urandom_range(0, 1) == 1);
      end
      if (become_valid) begin valid_exp = 1'b1; hold = hold_len; end
      if ((exp_done < 0 || c < exp_done) && $urandom_range(0, 7) == 0) begin
        start = 1'b1; seq_len = SW'($urandom_range(0, 127)); z_in = rand_x();
      end
      if (exp_done > 0 && c >= exp_done + 3) finished = 1'b1;
    end
    start = 1'b0; cell_done = 1'b0;
    check("run_end", finished, 1);
    check("transfers", step, eff);
    err_model = to_mode;
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    start = 1'b1; seq_len = SW'(4); z_in = rand_x();
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_launch", cell_start, 1);
    @(negedge clk);
    cell_done = 1'b1; cell_h_out = rand_h(); cell_c_out = rand_h(); out_ready = 1'b0;
    @(negedge clk);
    cell_done = 1'b0;
    check("rst_pre_valid", out_if.out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    err_model = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    run_seq(3, 0, 100, 1'b0, 1'b1);
    run_seq(2, 10, 100, 1'b0, 1'b0);
    run_seq(0, 0, 100, 1'b0, 1'b0);
    run_seq(1, 0, 100, 1'b0, 1'b1);
    run_seq(100, 0, 70, 1'b0, 1'b0);
    reset_mid_run();
    run_seq(3, 0, 100, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_seq($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(30, 100), 1'b0, 1'b0);
`ifdef DEC_SEQ_TIMEOUT_EN
    run_seq(3, 0, 100, 1'b1, 1'b0);
    run_seq(2, 0, 100, 1'b0, 1'b0);
    run_seq(4, 0, 100, 1'b1, 1'b0);
    reset_mid_run();
    run_seq(2, 1, 100, 1'b0, 1'b0);
`endif
    run_seq(MAXS, 0, 100, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
